// File: rtl/switch_pkg.sv
// switch_pkg: shared definitions for the N-port packet switch.
//   state_t        - ingress framing FSM states
//   BCAST_ADDR_DEF - default broadcast destination address
//   idx_w()        - width of a table/port index, never less than 1 bit
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP,
        WAIT_END
    } state_t;

    localparam logic [7:0] BCAST_ADDR_DEF = 8'hFF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_fifo.sv
// switch_fifo: single-clock egress FIFO with a registered read port.
//   clk, reset  - rising-edge clock, asynchronous active-high reset (flush)
//   write_enb   - push data_in (ignored when full)
//   read        - pop; data_out shows the popped entry from the next cycle
//                 and holds it until the following pop (ignored when empty)
//   data_in     - write data
//   data_out    - last popped entry
//   empty, full - occupancy flags (full when count == FIFO_DEPTH)
module switch_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enb,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic [DATA_W-1:0] data_out_q;
    logic              do_wr;
    logic              do_rd;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign do_wr    = write_enb & ~full;
    assign do_rd    = read & ~empty;
    assign data_out = data_out_q;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                data_out_q <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is flushed through the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/switch_nport.sv
// switch_nport: routes a framed ingress byte stream to N egress FIFOs by
// its first byte (DA), matched against a programmable address table, with
// optional broadcast, ingress backpressure and a saturating drop counter.
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   data_status  - high for every byte of a packet
//   data         - ingress byte (first byte of a packet is the DA)
//   hold         - ingress byte not accepted this cycle
//   port_data    - egress bytes, port i at [i*DATA_W +: DATA_W]
//   ready        - per-port FIFO non-empty
//   read         - per-port pop request
//   mem_en, mem_rd_wr, mem_add, mem_data, mem_rdata - address table access
//   drop_cnt     - number of packets dropped for lack of a table match
module switch_nport
    import switch_pkg::*;
#(
    parameter int              N_PORTS    = 4,
    parameter int              DATA_W     = 8,
    parameter int              FIFO_DEPTH = 16,
    parameter bit              BCAST_EN   = 1'b1,
    parameter logic [DATA_W-1:0] BCAST_ADDR = DATA_W'(BCAST_ADDR_DEF),
    parameter int              CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        data_status,
    input  logic [DATA_W-1:0]           data,
    output logic                        hold,
    output logic [N_PORTS*DATA_W-1:0]   port_data,
    output logic [N_PORTS-1:0]          ready,
    input  logic [N_PORTS-1:0]          read,
    input  logic                        mem_en,
    input  logic                        mem_rd_wr,
    input  logic [idx_w(N_PORTS)-1:0]   mem_add,
    input  logic [DATA_W-1:0]           mem_data,
    output logic [DATA_W-1:0]           mem_rdata,
    output logic [CNT_W-1:0]            drop_cnt
);

    state_t              state_q, state_d;
    logic [N_PORTS-1:0]  dest_mask_q, dest_mask_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]   mem_rdata_q;
    logic [DATA_W-1:0]   table_q [N_PORTS];
    logic                post_rst_q;

    logic [N_PORTS-1:0]  lookup_mask;
    logic                found;
    logic [N_PORTS-1:0]  mask_use;
    logic [N_PORTS-1:0]  wr_en;
    logic [N_PORTS-1:0]  full;
    logic [N_PORTS-1:0]  empty;
    logic                addr_ok;

    assign addr_ok   = (int'(mem_add) < N_PORTS);
    assign drop_cnt  = drop_cnt_q;
    assign mem_rdata = mem_rdata_q;
    assign ready     = ~empty;

    // DA lookup: broadcast overrides the table, otherwise lowest match wins.
    always_comb begin
        lookup_mask = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!found && table_q[i] == data) begin
                lookup_mask[i] = 1'b1;
                found          = 1'b1;
            end
        end
        if (BCAST_EN && data == BCAST_ADDR) begin
            lookup_mask = '1;
        end
    end

    // Ports the current ingress byte targets. The first cycle after reset
    // is excluded so a packet cut by reset is never forwarded.
    always_comb begin
        mask_use = '0;
        case (state_q)
            IDLE:    if (data_status && !post_rst_q) mask_use = lookup_mask;
            FWD:     if (data_status) mask_use = dest_mask_q;
            default: mask_use = '0;
        endcase
    end

    // Any full target stalls the whole byte, so broadcasts are never partial.
    assign hold  = |(mask_use & full);
    assign wr_en = hold ? '0 : mask_use;

    always_comb begin
        state_d     = state_q;
        dest_mask_d = dest_mask_q;
        drop_cnt_d  = drop_cnt_q;
        case (state_q)
            IDLE: begin
                if (data_status) begin
                    if (post_rst_q) begin
                        state_d = WAIT_END;
                    end else if (lookup_mask == '0) begin
                        state_d = DROP;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
                    end else if (!hold) begin
                        state_d     = FWD;
                        dest_mask_d = lookup_mask;
                    end
                end
            end
            FWD, DROP, WAIT_END: begin
                if (!data_status) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dest_mask_q <= '0;
            drop_cnt_q  <= '0;
            mem_rdata_q <= '0;
            post_rst_q  <= 1'b1;
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                table_q[i] <= DATA_W'(i);
            end
        end else begin
            state_q     <= state_d;
            dest_mask_q <= dest_mask_d;
            drop_cnt_q  <= drop_cnt_d;
            post_rst_q  <= 1'b0;
            if (mem_en && mem_rd_wr && addr_ok) begin
                table_q[mem_add] <= mem_data;
            end
            if (mem_en && !mem_rd_wr) begin
                mem_rdata_q <= addr_ok ? table_q[mem_add] : '0;
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        switch_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .write_enb (wr_en[g]),
            .read      (read[g]),
            .data_in   (data),
            .data_out  (port_data[g*DATA_W +: DATA_W]),
            .empty     (empty[g]),
            .full      (full[g])
        );
    end

endmodule

// File: tb/tb_switch_nport.sv
// tb_switch_nport: directed stimulus for switch_nport, checked every cycle
// against a queue-based packet model, plus literal expectations per test.
module tb_switch_nport;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           data_status = 1'b0;
    logic [W-1:0]   data = '0;
    logic           hold;
    logic [N*W-1:0] port_data;
    logic [N-1:0]   ready;
    logic [N-1:0]   read = '0;
    logic           mem_en = 1'b0;
    logic           mem_rd_wr = 1'b0;
    logic [1:0]     mem_add = '0;
    logic [W-1:0]   mem_data = '0;
    logic [W-1:0]   mem_rdata;
    logic [CW-1:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_nport #(
        .N_PORTS    (N),
        .DATA_W     (W),
        .FIFO_DEPTH (D),
        .BCAST_EN   (1'b1),
        .BCAST_ADDR (8'hFF),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_status (data_status),
        .data        (data),
        .hold        (hold),
        .port_data   (port_data),
        .ready       (ready),
        .read        (read),
        .mem_en      (mem_en),
        .mem_rd_wr   (mem_rd_wr),
        .mem_add     (mem_add),
        .mem_data    (mem_data),
        .mem_rdata   (mem_rdata),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: packets as byte queues ----------------
    logic [W-1:0] mq [N][$];
    logic [W-1:0] m_tab [N];
    logic [W-1:0] m_pdata [N];
    logic [W-1:0] m_rdata = '0;
    int           m_drop = 0;
    bit           m_in_pkt = 1'b0;   // forwarding a packet to m_dest
    bit           m_discard = 1'b0;  // skipping bytes until the gap
    bit           m_fresh = 1'b1;    // first edge after reset
    logic [N-1:0] m_dest = '0;

    function automatic logic [N-1:0] m_lookup(input logic [W-1:0] da);
        if (da == 8'hFF) return '1;
        for (int i = 0; i < N; i++)
            if (m_tab[i] == da) return 4'b0001 << i;
        return '0;
    endfunction

    function automatic logic [N-1:0] m_target();
        if (!data_status) return '0;
        if (m_in_pkt) return m_dest;
        if (m_discard || m_fresh) return '0;
        return m_lookup(data);
    endfunction

    function automatic bit m_hold();
        logic [N-1:0] t;
        t = m_target();
        for (int i = 0; i < N; i++)
            if (t[i] && mq[i].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                m_tab[i]   = W'(i);
                m_pdata[i] = '0;
            end
            m_rdata   = '0;
            m_drop    = 0;
            m_in_pkt  = 1'b0;
            m_discard = 1'b0;
            m_fresh   = 1'b1;
            m_dest    = '0;
        end else begin
            logic [N-1:0] t;
            bit h;
            t = m_target();
            h = m_hold();
            for (int i = 0; i < N; i++)
                if (read[i] && mq[i].size() > 0) m_pdata[i] = mq[i].pop_front();
            if (!h)
                for (int i = 0; i < N; i++)
                    if (t[i]) mq[i].push_back(data);
            if (mem_en) begin
                if (mem_rd_wr) m_tab[mem_add] = mem_data;
                else m_rdata = m_tab[mem_add];
            end
            if (!data_status) begin
                m_in_pkt  = 1'b0;
                m_discard = 1'b0;
            end else if (!m_in_pkt && !m_discard) begin
                if (m_fresh) begin
                    m_discard = 1'b1;
                end else if (t == '0) begin
                    m_discard = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else if (!h) begin
                    m_in_pkt = 1'b1;
                    m_dest   = t;
                end
            end
            m_fresh = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("hold", {31'b0, hold}, {31'b0, m_hold()});
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ready%0d", i), {31'b0, ready[i]}, {31'b0, (mq[i].size() != 0)});
            chk($sformatf("port_data%0d", i), 32'(port_data[i*W +: W]), 32'(m_pdata[i]));
        end
        chk("drop_cnt", 32'(drop_cnt), m_drop);
        chk("mem_rdata", 32'(mem_rdata), 32'(m_rdata));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte and keep it stable until an edge accepts it.
    task automatic put(input logic [W-1:0] b);
        logic h;
        int n;
        data_status = 1'b1;
        data = b;
        n = 0;
        do begin
            @(negedge clk);
            h = hold;
            @(posedge clk);
            #1;
            n++;
        end while (h && n < 60);
        chk("accept", {31'b0, h}, 32'd0);
    endtask

    task automatic gap();
        data_status = 1'b0;
        tick();
    endtask

    task automatic pop_exp(input int p, input logic [W-1:0] e);
        read[p] = 1'b1;
        tick();
        read[p] = 1'b0;
        chk($sformatf("pop%0d", p), 32'(port_data[p*W +: W]), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_hold", {31'b0, hold}, 32'd0);
        chk("rst_rdata", 32'(mem_rdata), 32'd0);
        chk("rst_pdata", port_data, 32'd0);
        reset = 1'b0;
        tick();

        // Unicast to port 2
        put(8'h02);
        chk("uni_ready", 32'(ready), 32'h4);
        put(8'hA1);
        put(8'hA2);
        gap();
        pop_exp(2, 8'h02);
        pop_exp(2, 8'hA1);
        pop_exp(2, 8'hA2);
        chk("uni_empty", 32'(ready), 32'd0);

        // Table remap: entry 1 -> 0x55, read back, then route
        mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 2'd1; mem_data = 8'h55;
        tick();
        mem_rd_wr = 1'b0;
        tick();
        mem_en = 1'b0;
        chk("tbl_rd", 32'(mem_rdata), 32'h55);
        put(8'h55); put(8'hB1); put(8'hB2); put(8'hB3);
        gap();
        chk("remap_ready", 32'(ready), 32'h2);
        pop_exp(1, 8'h55);
        pop_exp(1, 8'hB1);
        pop_exp(1, 8'hB2);
        pop_exp(1, 8'hB3);

        // Unmatched DA is dropped and counted
        for (int r = 1; r <= 2; r++) begin
            put(8'h77);
            for (int k = 0; k < 5; k++) put(8'hC0 + W'(k));
            gap();
            chk("drop_cnt_lit", 32'(drop_cnt), r);
            chk("drop_ready", 32'(ready), 32'd0);
        end

        // Backpressure on a full port 0
        put(8'h00);
        for (int k = 1; k < 16; k++) put(W'(k));
        gap();
        data_status = 1'b1;
        data = 8'h00;
        tick();
        tick();
        chk("bp_hold", {31'b0, hold}, 32'd1);
        chk("bp_ready", 32'(ready), 32'h1);
        pop_exp(0, 8'h00);
        chk("bp_release", {31'b0, hold}, 32'd0);
        put(8'h00);
        gap();
        for (int k = 1; k < 16; k++) pop_exp(0, W'(k));
        pop_exp(0, 8'h00);
        chk("bp_empty", 32'(ready), 32'd0);

        // Broadcast
        put(8'hFF);
        chk("bc_ready", 32'(ready), 32'hF);
        put(8'h3C);
        gap();
        for (int p = 0; p < N; p++) begin
            pop_exp(p, 8'hFF);
            pop_exp(p, 8'h3C);
        end

        // Broadcast stalled by a full port 3
        put(8'h03);
        for (int k = 1; k < 16; k++) put(8'h30 + W'(k));
        gap();
        data_status = 1'b1;
        data = 8'hFF;
        tick();
        tick();
        chk("bcst_hold", {31'b0, hold}, 32'd1);
        chk("bcst_nopart", 32'(ready), 32'h8);
        pop_exp(3, 8'h03);
        put(8'hFF);
        chk("bcst_ready", 32'(ready), 32'hF);
        data = 8'h3C;
        tick();
        chk("bcst_hold2", {31'b0, hold}, 32'd1);
        pop_exp(3, 8'h31);
        put(8'h3C);
        gap();
        for (int p = 0; p < 3; p++) begin
            pop_exp(p, 8'hFF);
            pop_exp(p, 8'h3C);
        end
        for (int k = 2; k < 16; k++) pop_exp(3, 8'h30 + W'(k));
        pop_exp(3, 8'hFF);
        pop_exp(3, 8'h3C);
        chk("bcst_empty", 32'(ready), 32'd0);

        // Reset in the middle of a 6-byte packet
        put(8'h02);
        put(8'hD1);
        data = 8'hD2;
        reset = 1'b1;
        tick();
        tick();
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        data = 8'h03;
        reset = 1'b0;
        tick();
        data = 8'hD4;
        tick();
        data = 8'hD5;
        tick();
        gap();
        chk("tail_ignored", 32'(ready), 32'd0);
        chk("tail_nodrop", 32'(drop_cnt), 32'd0);
        put(8'h03);
        put(8'hE5);
        gap();
        chk("post_rst_ready", 32'(ready), 32'h8);
        pop_exp(3, 8'h03);
        pop_exp(3, 8'hE5);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
